// File: rtl/eth_recv_pkg.sv
// Shared types, octet constants and field lengths for the frame receiver.
package eth_recv_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StPreamble,
        StSfd,
        StMacDst,
        StMacSrc,
        StLen,
        StPayload,
        StFcs,
        StReport
    } state_t;

    typedef enum logic [3:0] {
        ErrNone     = 4'd0,
        ErrPreamble = 4'd1,
        ErrSfd      = 4'd2,
        ErrAddr     = 4'd3,
        ErrLength   = 4'd4,
        ErrFcs      = 4'd5,
        ErrTimeout  = 4'd6
    } err_code_t;

    localparam logic [7:0]  PREAMBLE_OCTET = 8'hAA;
    localparam logic [7:0]  SFD_OCTET      = 8'hAB;
    localparam logic [47:0] BCAST_ADDR     = 48'hFF_FF_FF_FF_FF_FF;

    localparam int unsigned PREAMBLE_LEN = 7;
    localparam int unsigned SFD_LEN      = 1;
    localparam int unsigned MACDST_LEN   = 6;
    localparam int unsigned MACSRC_LEN   = 6;
    localparam int unsigned LEN_LEN      = 2;
    localparam int unsigned FCS_LEN      = 4;

    // Final check byte that brings the running modulo-256 sum back to zero.
    function automatic logic [7:0] fcs_expected(input logic [7:0] sum);
        return 8'h00 - sum;
    endfunction

    // True when cnt indexes the last byte of a field of length len.
    function automatic logic field_done(input logic [2:0] cnt, input int unsigned len);
        return cnt == 3'(len - 1);
    endfunction

endpackage

// File: rtl/eth_addr_match.sv
// Combinational destination-address filter: promiscuous, table hit or broadcast.
module eth_addr_match
    import eth_recv_pkg::*;
#(
    parameter int unsigned               NUM_ADDRS    = 2,
    parameter logic [NUM_ADDRS*48-1:0]   ADDR_TABLE   = {48'h00_0a_95_9d_68_16,
                                                         48'h02_00_00_00_00_01},
    parameter bit                        ACCEPT_BCAST = 1'b1
) (
    input  logic [47:0] dest,
    input  logic        promisc,
    output logic        hit
);

    always_comb begin
        hit = promisc || (ACCEPT_BCAST && (dest == BCAST_ADDR));
        for (int unsigned i = 0; i < NUM_ADDRS; i++) begin
            if (dest == ADDR_TABLE[i*48 +: 48]) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_frame_recv.sv
// Byte-serial frame receiver: preamble/SFD sync, address filter, length check,
// payload forwarding with one-cycle latency and an additive frame check.
module eth_frame_recv
    import eth_recv_pkg::*;
#(
    parameter int unsigned             NUM_ADDRS    = 2,
    parameter logic [NUM_ADDRS*48-1:0] ADDR_TABLE   = {48'h00_0a_95_9d_68_16,
                                                       48'h02_00_00_00_00_01},
    parameter bit                      ACCEPT_BCAST = 1'b1,
    parameter int unsigned             MAX_PAYLOAD  = 1500,
    parameter int unsigned             GAP_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_vld,
    input  logic        promisc,
    output logic [7:0]  out_data,
    output logic        out_vld,
    output logic        out_last,
    output logic        sts_vld,
    output logic        sts_ok,
    output logic [3:0]  sts_code,
    output logic        busy,
    output logic [15:0] cnt_ok,
    output logic [15:0] cnt_err
);

    localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
    localparam logic [15:0] GAP_LAST = 16'(GAP_TIMEOUT - 1);

    state_t      state_q;
    logic [2:0]  field_cnt_q;
    logic [39:0] dst_q;
    logic [7:0]  len_hi_q;
    logic [15:0] remain_q;
    logic [7:0]  sum_q;
    logic        match_q;
    logic        fcs_bad_q;
    logic [15:0] gap_q;
    logic [7:0]  out_data_q;
    logic        out_vld_q;
    logic        out_last_q;
    logic        sts_vld_q;
    logic        sts_ok_q;
    err_code_t   sts_code_q;
    logic [15:0] cnt_ok_q;
    logic [15:0] cnt_err_q;

    logic [47:0] dst_next;
    logic [15:0] len_next;
    logic [7:0]  sum_next;
    logic        addr_hit;
    logic        rpt_req;
    err_code_t   rpt_code;

    assign dst_next = {dst_q, in_data};
    assign len_next = {len_hi_q, in_data};
    assign sum_next = sum_q + in_data;

    eth_addr_match #(
        .NUM_ADDRS   (NUM_ADDRS),
        .ADDR_TABLE  (ADDR_TABLE),
        .ACCEPT_BCAST(ACCEPT_BCAST)
    ) u_addr_match (
        .dest   (dst_next),
        .promisc(promisc),
        .hit    (addr_hit)
    );

    // Every way a frame can end, timeout first since it needs no byte.
    always_comb begin
        rpt_req  = 1'b0;
        rpt_code = ErrNone;
        if (state_q != StIdle && state_q != StReport && !in_vld && gap_q == GAP_LAST) begin
            rpt_req  = 1'b1;
            rpt_code = ErrTimeout;
        end else if (in_vld) begin
            case (state_q)
                StPreamble: begin
                    if (in_data != PREAMBLE_OCTET) begin
                        rpt_req  = 1'b1;
                        rpt_code = ErrPreamble;
                    end
                end
                StSfd: begin
                    if (in_data != SFD_OCTET) begin
                        rpt_req  = 1'b1;
                        rpt_code = ErrSfd;
                    end
                end
                StLen: begin
                    if (field_done(field_cnt_q, LEN_LEN) &&
                        (len_next == 16'd0 || len_next > MAX_LEN)) begin
                        rpt_req  = 1'b1;
                        rpt_code = ErrLength;
                    end
                end
                StFcs: begin
                    if (field_done(field_cnt_q, FCS_LEN)) begin
                        rpt_req = 1'b1;
                        if (fcs_bad_q || in_data != fcs_expected(sum_q)) begin
                            rpt_code = ErrFcs;
                        end else if (!match_q) begin
                            rpt_code = ErrAddr;
                        end else begin
                            rpt_code = ErrNone;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            field_cnt_q <= '0;
            dst_q       <= '0;
            len_hi_q    <= '0;
            remain_q    <= '0;
            sum_q       <= '0;
            match_q     <= 1'b0;
            fcs_bad_q   <= 1'b0;
            gap_q       <= '0;
            out_data_q  <= '0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            sts_vld_q   <= 1'b0;
            sts_ok_q    <= 1'b0;
            sts_code_q  <= ErrNone;
            cnt_ok_q    <= '0;
            cnt_err_q   <= '0;
        end else begin
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            sts_vld_q  <= 1'b0;
            sts_ok_q   <= 1'b0;
            sts_code_q <= ErrNone;
            if (rpt_req) begin
                state_q    <= StReport;
                gap_q      <= '0;
                sts_vld_q  <= 1'b1;
                sts_ok_q   <= (rpt_code == ErrNone);
                sts_code_q <= rpt_code;
                if (rpt_code == ErrNone) begin
                    if (cnt_ok_q != 16'hFFFF) cnt_ok_q <= cnt_ok_q + 16'd1;
                end else begin
                    if (cnt_err_q != 16'hFFFF) cnt_err_q <= cnt_err_q + 16'd1;
                end
            end else if (state_q == StReport) begin
                state_q     <= StIdle;
                field_cnt_q <= '0;
                sum_q       <= '0;
                len_hi_q    <= '0;
                remain_q    <= '0;
                match_q     <= 1'b0;
                fcs_bad_q   <= 1'b0;
                gap_q       <= '0;
            end else if (!in_vld) begin
                if (state_q != StIdle) gap_q <= gap_q + 16'd1;
            end else begin
                gap_q <= '0;
                case (state_q)
                    StIdle: begin
                        if (in_data == PREAMBLE_OCTET) begin
                            state_q     <= StPreamble;
                            field_cnt_q <= 3'd1;
                            sum_q       <= '0;
                            match_q     <= 1'b0;
                            fcs_bad_q   <= 1'b0;
                        end
                    end
                    StPreamble: begin
                        if (field_done(field_cnt_q, PREAMBLE_LEN)) begin
                            state_q     <= StSfd;
                            field_cnt_q <= '0;
                        end else begin
                            field_cnt_q <= field_cnt_q + 3'd1;
                        end
                    end
                    StSfd: begin
                        if (field_done(field_cnt_q, SFD_LEN)) begin
                            state_q     <= StMacDst;
                            field_cnt_q <= '0;
                        end else begin
                            field_cnt_q <= field_cnt_q + 3'd1;
                        end
                    end
                    StMacDst: begin
                        dst_q <= dst_next[39:0];
                        sum_q <= sum_next;
                        if (field_done(field_cnt_q, MACDST_LEN)) begin
                            match_q     <= addr_hit;
                            state_q     <= StMacSrc;
                            field_cnt_q <= '0;
                        end else begin
                            field_cnt_q <= field_cnt_q + 3'd1;
                        end
                    end
                    StMacSrc: begin
                        sum_q <= sum_next;
                        if (field_done(field_cnt_q, MACSRC_LEN)) begin
                            state_q     <= StLen;
                            field_cnt_q <= '0;
                        end else begin
                            field_cnt_q <= field_cnt_q + 3'd1;
                        end
                    end
                    StLen: begin
                        sum_q    <= sum_next;
                        len_hi_q <= in_data;
                        if (field_done(field_cnt_q, LEN_LEN)) begin
                            remain_q    <= len_next;
                            state_q     <= StPayload;
                            field_cnt_q <= '0;
                        end else begin
                            field_cnt_q <= field_cnt_q + 3'd1;
                        end
                    end
                    StPayload: begin
                        sum_q    <= sum_next;
                        remain_q <= remain_q - 16'd1;
                        // Missed frames are still parsed, just not forwarded.
                        if (match_q) begin
                            out_data_q <= in_data;
                            out_vld_q  <= 1'b1;
                            out_last_q <= (remain_q == 16'd1);
                        end
                        if (remain_q == 16'd1) begin
                            state_q     <= StFcs;
                            field_cnt_q <= '0;
                        end
                    end
                    StFcs: begin
                        if (in_data != 8'h00) fcs_bad_q <= 1'b1;
                        field_cnt_q <= field_cnt_q + 3'd1;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign out_data = out_data_q;
    assign out_vld  = out_vld_q;
    assign out_last = out_last_q;
    assign sts_vld  = sts_vld_q;
    assign sts_ok   = sts_ok_q;
    assign sts_code = sts_code_q;
    assign busy     = (state_q != StIdle);
    assign cnt_ok   = cnt_ok_q;
    assign cnt_err  = cnt_err_q;

endmodule

// File: tb/tb_eth_frame_recv.sv
// Randomized frame bench: expectations derived from the frame fields that built each frame.
module tb_eth_frame_recv;

    localparam logic [47:0] ADDR0 = 48'h02_00_00_00_00_01;
    localparam logic [47:0] ADDR1 = 48'h00_0a_95_9d_68_16;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] OTHER = 48'h00_11_22_33_44_55;
    localparam int          GAP   = 16;
    localparam int          MAXP  = 1500;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_vld;
    logic        promisc;
    logic [7:0]  out_data;
    logic        out_vld;
    logic        out_last;
    logic        sts_vld;
    logic        sts_ok;
    logic [3:0]  sts_code;
    logic        busy;
    logic [15:0] cnt_ok;
    logic [15:0] cnt_err;

    always #5 clk = ~clk;

    eth_frame_recv dut (
        .clk     (clk),
        .rst     (rst),
        .in_data (in_data),
        .in_vld  (in_vld),
        .promisc (promisc),
        .out_data(out_data),
        .out_vld (out_vld),
        .out_last(out_last),
        .sts_vld (sts_vld),
        .sts_ok  (sts_ok),
        .sts_code(sts_code),
        .busy    (busy),
        .cnt_ok  (cnt_ok),
        .cnt_err (cnt_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_ok   = 0;
    int exp_err  = 0;

    logic [7:0] got_data[$];
    logic       got_last[$];
    logic [3:0] got_code[$];
    logic [7:0] pay[$];

    always @(negedge clk) begin
        if (out_vld) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
        end
        if (sts_vld) got_code.push_back(sts_code);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] d);
        in_vld  = v;
        in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_mode);
        if (gap_mode == 1) cyc(1'b0, 8'($urandom));
        if (gap_mode == 2) repeat ($urandom_range(0, 2)) cyc(1'b0, 8'($urandom));
        cyc(1'b1, b);
    endtask

    task automatic clear_mon();
        got_data.delete();
        got_last.delete();
        got_code.delete();
    endtask

    // Called right after the cycle that should have ended the frame.
    task automatic check_report(input string tag, input int code);
        check_eq({tag, "_sts_vld"}, 32'(sts_vld), 32'd1);
        check_eq({tag, "_sts_code"}, 32'(sts_code), 32'(code));
        check_eq({tag, "_sts_ok"}, 32'(sts_ok), 32'(code == 0));
        if (code == 0) exp_ok++;
        else exp_err++;
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_cnt_ok"}, 32'(cnt_ok), 32'(exp_ok));
        check_eq({tag, "_cnt_err"}, 32'(cnt_err), 32'(exp_err));
    endtask

    task automatic fill_pay(input int len);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    endtask

    // fcs_err: 0 none, 1 check byte off by one, 2 leading FCS byte nonzero.
    task automatic run_frame(input string tag, input logic [47:0] dest, input logic prom,
                             input int len, input int fcs_err, input int gap_mode,
                             input int stall_at, input int stall_len);
        logic [7:0]  bytes[$];
        logic [47:0] src;
        logic [15:0] len16;
        logic [7:0]  chk;
        logic        match;
        logic        len_bad;
        logic        stop;
        int          sum;
        int          pay_start;
        int          code;
        int          exp_n;
        clear_mon();
        promisc = prom;
        match   = prom || dest == ADDR0 || dest == ADDR1 || dest == BCAST;
        len_bad = (len == 0 || len > MAXP);
        src     = {16'($urandom), 32'($urandom)};
        len16   = 16'(len);
        for (int i = 0; i < 6; i++) bytes.push_back(dest[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) bytes.push_back(src[47-8*i -: 8]);
        bytes.push_back(len16[15:8]);
        bytes.push_back(len16[7:0]);
        pay_start = bytes.size();
        if (!len_bad) begin
            foreach (pay[i]) bytes.push_back(pay[i]);
            sum = 0;
            foreach (bytes[i]) sum += int'(bytes[i]);
            chk = 8'((256 - (sum % 256)) % 256);
            bytes.push_back(fcs_err == 2 ? 8'h01 : 8'h00);
            bytes.push_back(8'h00);
            bytes.push_back(8'h00);
            bytes.push_back(fcs_err == 1 ? chk + 8'd1 : chk);
        end
        if (stall_len >= GAP) code = 6;
        else if (len_bad) code = 4;
        else if (fcs_err != 0) code = 5;
        else if (!match) code = 3;
        else code = 0;
        if (code == 4) exp_n = 0;
        else if (!match) exp_n = 0;
        else if (code == 6) exp_n = stall_at;
        else exp_n = len;

        for (int i = 0; i < 7; i++) send_byte(8'hAA, gap_mode);
        send_byte(8'hAB, gap_mode);
        stop = 1'b0;
        for (int i = 0; i < bytes.size() && !stop; i++) begin
            if (stall_len > 0 && i == pay_start + stall_at) begin
                repeat (stall_len) cyc(1'b0, 8'($urandom));
                if (stall_len >= GAP) stop = 1'b1;
            end
            if (!stop) send_byte(bytes[i], gap_mode);
        end
        check_report(tag, code);
        check_eq({tag, "_sts_pulses"}, got_code.size(), 32'd1);
        check_eq({tag, "_out_count"}, got_data.size(), 32'(exp_n));
        for (int i = 0; i < got_data.size() && i < exp_n; i++) begin
            check_eq({tag, "_out_data"}, 32'(got_data[i]), 32'(pay[i]));
            check_eq({tag, "_out_last"}, 32'(got_last[i]), 32'(code != 6 && i == exp_n - 1));
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    initial begin
        logic [47:0] dest;
        int          len;
        int          sel;
        int          s_at;
        int          s_len;
        int          n_last;
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_data = 8'h00;
        promisc = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, 8'h00);
        rst = 1'b0;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_out_vld", 32'(out_vld), 32'd0);
        check_eq("rst_sts_vld", 32'(sts_vld), 32'd0);
        check_eq("rst_cnt_ok", 32'(cnt_ok), 32'd0);
        check_eq("rst_cnt_err", 32'(cnt_err), 32'd0);

        pay = '{8'h01, 8'h02, 8'h03};
        run_frame("good", ADDR1, 1'b0, 3, 0, 0, -1, 0);
        run_frame("miss", OTHER, 1'b0, 3, 0, 0, -1, 0);
        run_frame("promisc", OTHER, 1'b1, 3, 0, 0, -1, 0);
        run_frame("bad_fcs", ADDR1, 1'b0, 3, 1, 0, -1, 0);
        run_frame("gappy", ADDR1, 1'b0, 3, 0, 1, -1, 0);
        run_frame("stall15", ADDR1, 1'b0, 3, 0, 0, 1, GAP - 1);
        run_frame("timeout", ADDR1, 1'b0, 3, 0, 0, 1, GAP);
        run_frame("miss_badfcs", OTHER, 1'b0, 3, 2, 0, -1, 0);
        pay.delete();
        run_frame("len1501", ADDR1, 1'b0, 1501, 0, 0, -1, 0);
        run_frame("len0", ADDR0, 1'b0, 0, 0, 0, -1, 0);
        fill_pay(MAXP);
        run_frame("len1500", BCAST, 1'b0, MAXP, 0, 0, -1, 0);

        clear_mon();
        repeat (3) cyc(1'b1, 8'hAA);
        cyc(1'b1, 8'h55);
        check_report("preamble_err", 1);
        repeat (8) cyc(1'b1, 8'hAA);
        check_report("sfd_err", 2);

        for (int f = 0; f < 25; f++) begin
            sel = $urandom_range(0, 3);
            dest = (sel == 0) ? ADDR0 : (sel == 1) ? ADDR1 : (sel == 2) ? BCAST
                 : {16'($urandom), 32'($urandom)};
            sel = $urandom_range(0, 9);
            len = (sel == 0) ? 0 : (sel == 1) ? MAXP + 1 + $urandom_range(0, 50)
                : $urandom_range(1, 24);
            s_at  = -1;
            s_len = 0;
            if (len > 0 && len <= MAXP) begin
                fill_pay(len);
                if ($urandom_range(0, 5) == 0) begin
                    s_at  = $urandom_range(0, len - 1);
                    s_len = ($urandom_range(0, 1) == 1) ? GAP : $urandom_range(3, GAP - 1);
                end
            end else begin
                pay.delete();
            end
            run_frame("rand", dest, ($urandom_range(0, 3) == 0),
                      len, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                      $urandom_range(0, 2), s_at, s_len);
        end

        // Reset in the middle of a forwarded payload.
        clear_mon();
        promisc = 1'b0;
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'hAA);
        cyc(1'b1, 8'hAB);
        for (int i = 0; i < 6; i++) cyc(1'b1, ADDR1[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h05);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(i + 16));
        rst = 1'b1;
        cyc(1'b0, 8'h00);
        rst = 1'b0;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_out_vld", 32'(out_vld), 32'd0);
        check_eq("midrst_cnt_ok", 32'(cnt_ok), 32'd0);
        check_eq("midrst_cnt_err", 32'(cnt_err), 32'd0);
        repeat (3) cyc(1'b0, 8'h00);
        n_last = 0;
        foreach (got_last[i]) if (got_last[i]) n_last++;
        check_eq("midrst_sts_pulses", got_code.size(), 32'd0);
        check_eq("midrst_out_count", got_data.size(), 32'd3);
        check_eq("midrst_no_last", 32'(n_last), 32'd0);
        exp_ok  = 0;
        exp_err = 0;
        pay = '{8'h01, 8'h02, 8'h03};
        run_frame("after_rst", ADDR1, 1'b0, 3, 0, 0, -1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
